// File: rtl/pr_bus_arbiter_if.sv
// pr_bus_arbiter_if: master-side requests, device-side strobes and interrupt vector of the bridge
interface pr_bus_arbiter_if;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_we, m1_we;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        gnt;
  logic [2:0]  dev_sel;
  logic [1:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic        dev_we;
  logic [31:0] dev_rdata0, dev_rdata1, dev_rdata2;
  logic [2:0]  dev_irq;
  logic [5:0]  hwint;
  logic        bus_err;
  modport slave (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
           dev_rdata0, dev_rdata1, dev_rdata2, dev_irq,
    output m0_ack, m1_ack, m0_rdata, m1_rdata, gnt, dev_sel, dev_addr, dev_wdata, dev_we, hwint, bus_err
  );
  modport master (
    output m0_req, m1_req, m0_addr, m1_addr, m0_wdata, m1_wdata, m0_we, m1_we,
           dev_rdata0, dev_rdata1, dev_rdata2, dev_irq,
    input  m0_ack, m1_ack, m0_rdata, m1_rdata, gnt, dev_sel, dev_addr, dev_wdata, dev_we, hwint, bus_err
  );
endinterface

// File: rtl/pr_bus_arbiter.sv
// pr_bus_arbiter: round-robin two-master bridge to three memory-mapped devices with fixed wait states
module pr_bus_arbiter #(
  parameter int WAIT_CYCLES = 1
) (
  input logic clk,
  input logic rst,
  pr_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic last_gnt, pick;
  logic [31:0] rdata, addr, rd;
  logic [2:0] sel;
  logic unused_addr;
  always_comb begin
    pick = bus.m0_req && bus.m1_req ? ~last_gnt : bus.m1_req;
    addr = pick ? bus.m1_addr : bus.m0_addr;
    // the fourth word of each timer window is a hole in the map
    sel = addr[31:16] != 16'h0 || addr[3:2] == 2'd3 ? 3'b000 :
          addr[15:4] == 12'h7F0 ? 3'b001 :
          addr[15:4] == 12'h7F1 ? 3'b010 :
          addr[15:2] == 14'h1FC8 ? 3'b100 : 3'b000;
    rd = bus.dev_sel[0] ? bus.dev_rdata0 :
         bus.dev_sel[1] ? bus.dev_rdata1 :
         bus.dev_sel[2] ? bus.dev_rdata2 : 32'h0;
  end
  assign unused_addr = ^addr[1:0];
  assign bus.m0_rdata = rdata;
  assign bus.m1_rdata = rdata;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      last_gnt <= 1'b1;
      rdata <= 32'h0;
      bus.gnt <= 1'b0;
      bus.dev_sel <= 3'b000;
      bus.dev_addr <= 2'd0;
      bus.dev_wdata <= 32'h0;
      bus.dev_we <= 1'b0;
      bus.m0_ack <= 1'b0;
      bus.m1_ack <= 1'b0;
      bus.bus_err <= 1'b0;
      bus.hwint <= 6'd0;
    end else begin
      bus.hwint <= {3'b000, bus.dev_irq};
      case (state)
        IDLE: if (bus.m0_req || bus.m1_req) begin
          state <= ACCESS;
          bus.gnt <= pick;
          last_gnt <= pick;
          bus.dev_sel <= sel;
          bus.dev_addr <= addr[3:2];
          bus.dev_wdata <= pick ? bus.m1_wdata : bus.m0_wdata;
          bus.dev_we <= (pick ? bus.m1_we : bus.m0_we) && sel != 3'b000;
          cnt <= 4'(WAIT_CYCLES);
        end
        ACCESS: begin
          bus.dev_we <= 1'b0;
          if (cnt == 4'd0) begin
            state <= DONE;
            rdata <= rd;
            bus.dev_sel <= 3'b000;
            bus.m0_ack <= ~bus.gnt;
            bus.m1_ack <= bus.gnt;
            bus.bus_err <= bus.dev_sel == 3'b000;
          end else cnt <= cnt - 4'd1;
        end
        DONE: begin
          state <= IDLE;
          bus.m0_ack <= 1'b0;
          bus.m1_ack <= 1'b0;
          bus.bus_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pr_bus_arbiter.sv
// tb_pr_bus_arbiter: directed scenarios for the bridge with hand-computed cycle-by-cycle expectations
module tb_pr_bus_arbiter;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  pr_bus_arbiter_if bus();
  pr_bus_arbiter #(.WAIT_CYCLES(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  logic [8:0] obs;
  assign obs = {bus.m0_ack, bus.m1_ack, bus.bus_err, bus.dev_we, bus.dev_sel, bus.dev_addr};
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_inputs;
    bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
    bus.m0_addr = 0; bus.m1_addr = 0; bus.m0_wdata = 0; bus.m1_wdata = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    idle_inputs();
    bus.dev_rdata0 = 0; bus.dev_rdata1 = 0; bus.dev_rdata2 = 0; bus.dev_irq = 0;
    tick(); tick();
    tests++;
    if ({obs, bus.gnt, bus.hwint} !== 16'h0) begin
      fails++; $display("FAIL reset_ctrl got %b %b %b exp 0", obs, bus.gnt, bus.hwint);
    end
    tests++;
    if ({bus.dev_wdata, bus.m0_rdata, bus.m1_rdata} !== 96'h0) begin
      fails++; $display("FAIL reset_data got %h %h %h exp 0", bus.dev_wdata, bus.m0_rdata, bus.m1_rdata);
    end
    rst = 0;
    tick();
  endtask
  task automatic test_read;
    logic [8:0] exp;
    bus.m0_req = 1; bus.m0_addr = 32'h0000_7F14; bus.m0_we = 0; bus.dev_rdata1 = 32'hDEAD_BEEF;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = i < 3 ? 9'b0000_010_01 : 9'b1000_000_01;
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL read_c%0d got %b exp %b", i, obs, exp); end
    end
    tests++;
    if (bus.m0_rdata !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL read_rdata got %h exp deadbeef", bus.m0_rdata);
    end
    bus.m0_req = 0;
    tick();
    tests++;
    if (obs[8:7] !== 2'b00) begin fails++; $display("FAIL read_ack_pulse got %b exp 00", obs[8:7]); end
  endtask
  task automatic test_write;
    logic [8:0] exp;
    int strobes = 0;
    bus.m1_req = 1; bus.m1_addr = 32'h0000_7F20; bus.m1_we = 1; bus.m1_wdata = 32'h1234_5678;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (bus.dev_we) strobes++;
      exp = i == 1 ? 9'b0001_100_00 : i == 2 ? 9'b0000_100_00 : 9'b0100_000_00;
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL write_c%0d got %b exp %b", i, obs, exp); end
      if (i == 1) begin
        tests++;
        if ({bus.gnt, bus.dev_wdata} !== {1'b1, 32'h1234_5678}) begin
          fails++; $display("FAIL write_data got gnt=%b %h exp gnt=1 12345678", bus.gnt, bus.dev_wdata);
        end
      end
    end
    bus.m1_req = 0; bus.m1_we = 0;
    tick();
    tests++;
    if (strobes != 1) begin fails++; $display("FAIL write_strobes got %0d exp 1", strobes); end
  endtask
  task automatic test_round_robin;
    logic [1:0] exp;
    rst = 1;
    tick();
    rst = 0;
    bus.m0_req = 1; bus.m0_addr = 32'h0000_7F00; bus.dev_rdata0 = 32'h1111_1111;
    bus.m1_req = 1; bus.m1_addr = 32'h0000_7F10; bus.dev_rdata1 = 32'h2222_2222;
    for (int c = 1; c <= 15; c++) begin
      tick();
      exp = c % 4 == 3 ? ((c / 4) % 2 == 0 ? 2'b10 : 2'b01) : 2'b00;
      tests++;
      if ({bus.m0_ack, bus.m1_ack} !== exp) begin
        fails++; $display("FAIL rr_ack_c%0d got %b exp %b", c, {bus.m0_ack, bus.m1_ack}, exp);
      end
      if (exp != 2'b00) begin
        tests++;
        if (bus.m0_rdata !== (exp[1] ? 32'h1111_1111 : 32'h2222_2222)) begin
          fails++; $display("FAIL rr_rdata_c%0d got %h", c, bus.m0_rdata);
        end
      end
    end
    bus.m0_req = 0; bus.m1_req = 0;
    tick();
  endtask
  task automatic test_unmapped;
    logic [8:0] exp;
    bus.dev_rdata0 = 32'hCAFE_F00D;
    for (int t = 0; t < 2; t++) begin
      bus.m0_req = 1; bus.m0_we = t == 0; bus.m0_wdata = 32'hA5A5_A5A5;
      bus.m0_addr = t == 0 ? 32'h0000_7F0C : 32'h0001_7F00;
      for (int i = 1; i <= 3; i++) begin
        tick();
        exp = {i == 3, 1'b0, i == 3, 1'b0, 3'b000, t == 0 ? 2'b11 : 2'b00};
        tests++;
        if (obs !== exp) begin fails++; $display("FAIL unmapped%0d_c%0d got %b exp %b", t, i, obs, exp); end
      end
      tests++;
      if (bus.m0_rdata !== 32'h0) begin fails++; $display("FAIL unmapped%0d_rdata got %h exp 0", t, bus.m0_rdata); end
      bus.m0_req = 0; bus.m0_we = 0;
      tick();
    end
  endtask
  task automatic test_reset_mid_write;
    logic [8:0] exp;
    int acks = 0;
    bus.m0_req = 1; bus.m0_addr = 32'h0000_7F04; bus.m0_we = 1; bus.m0_wdata = 32'h0BAD_F00D;
    tick();
    tests++;
    if (obs !== 9'b0001_001_01) begin fails++; $display("FAIL midrst_pre got %b exp 000100101", obs); end
    rst = 1;
    #1;
    tests++;
    if (obs !== 9'h0) begin fails++; $display("FAIL midrst_async got %b exp 0", obs); end
    bus.m0_req = 0; bus.m0_we = 0;
    tick();
    rst = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.m0_ack || bus.m1_ack) acks++;
    end
    tests++;
    if (acks != 0) begin fails++; $display("FAIL midrst_no_ack got %0d acks exp 0", acks); end
    bus.m0_req = 1; bus.m0_we = 1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp = i == 1 ? 9'b0001_001_01 : i == 2 ? 9'b0000_001_01 : 9'b1000_000_01;
      tests++;
      if (obs !== exp) begin fails++; $display("FAIL midrst_retry_c%0d got %b exp %b", i, obs, exp); end
    end
    bus.m0_req = 0; bus.m0_we = 0;
    tick();
  endtask
  task automatic test_irq;
    bus.dev_irq = 3'b101;
    #1;
    tests++;
    if (bus.hwint !== 6'b000000) begin fails++; $display("FAIL irq_lag got %b exp 000000", bus.hwint); end
    bus.m1_req = 1; bus.m1_addr = 32'h0000_7F18;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 3) bus.m1_req = 0;
      tests++;
      if (bus.hwint !== 6'b000101) begin fails++; $display("FAIL irq_c%0d got %b exp 000101", i, bus.hwint); end
    end
    bus.dev_irq = 3'b010;
    tick();
    tests++;
    if (bus.hwint !== 6'b000010) begin fails++; $display("FAIL irq_change got %b exp 000010", bus.hwint); end
  endtask
  initial begin
    test_reset();
    test_read();
    test_write();
    test_round_robin();
    test_unmapped();
    test_reset_mid_write();
    test_irq();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
